// File: rtl/dice_pkg.sv
// Shared face constants, FSM state encoding and face helpers for the dice roller.
package dice_pkg;

  localparam int          FACE_MIN  = 1;
  localparam int          FACE_MAX  = 6;
  localparam int          FACE_W    = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TUMBLE = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [FACE_W-1:0] opposite(input logic [FACE_W-1:0] f);
    return 3'd7 - f;
  endfunction

endpackage

// File: rtl/dice_face_step.sv
// One tumble step for a single die: pick the r-th face that is neither the
// current face nor its opposite; illegal faces recover to 1, held dice stay put.
module dice_face_step
  import dice_pkg::*;
(
  input  logic [FACE_W-1:0] face,
  input  logic [1:0]        r,
  input  logic              hold,
  output logic [FACE_W-1:0] next_face
);

  logic [FACE_W-1:0] opp_s;
  logic [FACE_W-1:0] pick_s;
  logic [FACE_W-1:0] cand_s;
  logic [2:0]        idx_s;

  // Scan faces in ascending order, counting allowed ones until index r is reached
  always_comb begin
    opp_s  = opposite(face);
    pick_s = 3'd1;
    cand_s = 3'd0;
    idx_s  = 3'd0;
    for (int v = FACE_MIN; v <= FACE_MAX; v++) begin
      cand_s = v[FACE_W-1:0];
      if ((cand_s != face) && (cand_s != opp_s)) begin
        if (idx_s == {1'b0, r}) begin
          pick_s = cand_s;
        end else begin
          pick_s = pick_s;
        end
        idx_s = idx_s + 3'd1;
      end else begin
        idx_s = idx_s;
      end
    end
    if (hold) begin
      next_face = face;
    end else if ((face == 3'd0) || (face == 3'd7)) begin
      next_face = 3'd1;
    end else begin
      next_face = pick_s;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Multi-die roller: LFSR-driven tumbling while Roll is high, then a geometric
// slow-down of SETTLE_STEPS steps ending in a one-cycle Valid with the face sum.
module dice_roller
  import dice_pkg::*;
#(
  parameter int          NUM_DICE     = 2,
  parameter int          BASE_DIV     = 2,
  parameter int          SETTLE_STEPS = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                              Clock,
  input  logic                              nReset,
  input  logic                              Roll,
  input  logic [NUM_DICE-1:0]               Hold,
  output logic [3*NUM_DICE-1:0]             DiceValue,
  output logic [$clog2(6*NUM_DICE+1)-1:0]   Sum,
  output logic                              Valid,
  output logic                              Busy
);

  localparam int          SW    = $clog2(6*NUM_DICE+1);
  localparam int          CNT_W = $clog2((BASE_DIV << SETTLE_STEPS) + 1);
  localparam int          K_W   = $clog2(SETTLE_STEPS + 1);
  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  state_t                  state_r, state_nxt_s;
  logic [15:0]             lfsr_r, lfsr_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s, tick_lim_s;
  logic [K_W-1:0]          k_r, k_nxt_s;
  logic [NUM_DICE-1:0]     hold_r, hold_nxt_s;
  logic [3*NUM_DICE-1:0]   face_r, face_nxt_s, stepped_s;
  logic [SW-1:0]           sum_r, sum_nxt_s;
  logic                    valid_r, busy_r;
  logic                    tick_s, step_s;

  assign lfsr_nxt_s = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
  assign tick_lim_s = (state_r == TUMBLE) ? CNT_W'(BASE_DIV - 1)
                                          : CNT_W'((BASE_DIV << k_r) - 1);
  assign tick_s     = (cnt_r == tick_lim_s);

  for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
    dice_face_step u_step (
      .face      (face_r[3*i +: 3]),
      .r         (lfsr_r[2*i +: 2]),
      .hold      (hold_r[i]),
      .next_face (stepped_s[3*i +: 3])
    );
  end

  // Next-state, tick counter, settle index and hold-latch control
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    k_nxt_s     = k_r;
    hold_nxt_s  = hold_r;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (Roll) begin
          state_nxt_s = TUMBLE;
          cnt_nxt_s   = '0;
          hold_nxt_s  = Hold;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TUMBLE: begin
        if (tick_s) begin
          step_s    = 1'b1;
          cnt_nxt_s = '0;
          if (!Roll) begin
            state_nxt_s = SETTLE;
            k_nxt_s     = K_W'(1);
          end else begin
            state_nxt_s = TUMBLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      SETTLE: begin
        // A new Roll press abandons the slow-down without taking a step
        if (Roll) begin
          state_nxt_s = TUMBLE;
          cnt_nxt_s   = '0;
        end else if (tick_s) begin
          step_s    = 1'b1;
          cnt_nxt_s = '0;
          if (k_r == K_W'(SETTLE_STEPS)) begin
            state_nxt_s = DONE;
          end else begin
            k_nxt_s = k_r + K_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        if (Roll) begin
          state_nxt_s = TUMBLE;
          cnt_nxt_s   = '0;
          hold_nxt_s  = Hold;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Face update and running total of the faces about to be registered
  always_comb begin
    if (step_s) begin
      face_nxt_s = stepped_s;
    end else begin
      face_nxt_s = face_r;
    end
    sum_nxt_s = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      sum_nxt_s = sum_nxt_s + SW'(face_nxt_s[3*i +: 3]);
    end
  end

  // State, LFSR, counters, faces and registered outputs
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
      lfsr_r  <= SEED;
      cnt_r   <= '0;
      k_r     <= '0;
      hold_r  <= '0;
      face_r  <= {NUM_DICE{3'd1}};
      sum_r   <= SW'(NUM_DICE);
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      lfsr_r  <= lfsr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      k_r     <= k_nxt_s;
      hold_r  <= hold_nxt_s;
      face_r  <= face_nxt_s;
      sum_r   <= (state_nxt_s == DONE) ? sum_nxt_s : sum_r;
      valid_r <= (state_nxt_s == DONE);
      busy_r  <= (state_nxt_s == TUMBLE) || (state_nxt_s == SETTLE);
    end
  end

  assign DiceValue = face_r;
  assign Sum       = sum_r;
  assign Valid     = valid_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: cycle-accurate face/LFSR model, scoreboard of
// expected results checked on Valid, plus an exhaustive dice_face_step table check.
module tb_dice_roller;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       Roll;
  logic [1:0] Hold;
  logic [5:0] DiceValue;
  logic [3:0] Sum;
  logic       Valid;
  logic       Busy;

  logic [2:0] uf, unext;
  logic [1:0] ur;
  logic       uh;

  typedef struct {
    logic [5:0] faces;
    logic [3:0] sum;
  } exp_t;

  exp_t        sb_q[$];
  int          steps_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] lfsr_m;
  logic [5:0]  faces_m;
  logic [1:0]  hold_m;
  int          roll_lo, roll_hi, roll2_lo, roll2_hi;

  dice_roller dut (
    .Clock(Clock), .nReset(nReset), .Roll(Roll), .Hold(Hold),
    .DiceValue(DiceValue), .Sum(Sum), .Valid(Valid), .Busy(Busy)
  );

  dice_face_step u_unit (.face(uf), .r(ur), .hold(uh), .next_face(unext));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_next(input logic [2:0] f, input logic [1:0] r);
    logic [11:0] lst;
    case (f)
      3'd1, 3'd6: lst = {3'd2, 3'd3, 3'd4, 3'd5};
      3'd2, 3'd5: lst = {3'd1, 3'd3, 3'd4, 3'd6};
      3'd3, 3'd4: lst = {3'd1, 3'd2, 3'd5, 3'd6};
      default:    lst = {4{3'd1}};
    endcase
    return lst[9 - 3*int'(r) +: 3];
  endfunction

  // Advance one clock; the model LFSR tracks the DUT's free-running register
  task automatic cyc();
    @(posedge Clock);
    if (nReset) lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    else        lfsr_m = 16'hACE1;
    @(negedge Clock);
  endtask

  // Every Valid must match the oldest outstanding expected result
  always @(negedge Clock) begin
    exp_t e;
    if (nReset && Valid) begin
      if (sb_q.size() == 0) begin
        check("valid_unexpected", Valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("valid_sum", Sum, e.sum);
        check("valid_faces", DiceValue, e.faces);
      end
    end
  end

  // Run one roll from IDLE: Roll windows and step edges are set up by the caller
  task automatic run_roll(input int done_edge, input logic [1:0] hold_in);
    logic [5:0] old;
    bit         stepped;
    exp_t       e;
    for (int ed = 0; ed <= done_edge + 1; ed++) begin
      Roll = ((ed >= roll_lo) && (ed <= roll_hi)) || ((ed >= roll2_lo) && (ed <= roll2_hi));
      Hold = (ed < 3) ? hold_in : ~hold_in;
      if (ed == 0) hold_m = hold_in;
      stepped = (steps_q.size() != 0) && (steps_q[0] == ed);
      old = faces_m;
      if (stepped) begin
        void'(steps_q.pop_front());
        for (int d = 0; d < 2; d++)
          if (!hold_m[d]) faces_m[3*d +: 3] = model_next(old[3*d +: 3], lfsr_m[2*d +: 2]);
      end
      if (ed == done_edge) begin
        e.faces = faces_m;
        e.sum   = 4'(faces_m[2:0]) + 4'(faces_m[5:3]);
        sb_q.push_back(e);
      end
      cyc();
      check($sformatf("faces_e%0d", ed), DiceValue, faces_m);
      check($sformatf("busy_e%0d", ed), Busy, (ed < done_edge));
      check($sformatf("valid_e%0d", ed), Valid, (ed == done_edge));
      if (stepped) begin
        for (int d = 0; d < 2; d++) begin
          if (!hold_m[d]) begin
            check("rule_ne_old", DiceValue[3*d +: 3] != old[3*d +: 3], 1'b1);
            check("rule_ne_opp", DiceValue[3*d +: 3] != 3'd7 - old[3*d +: 3], 1'b1);
            check("rule_range", (DiceValue[3*d +: 3] >= 3'd1) && (DiceValue[3*d +: 3] <= 3'd6), 1'b1);
          end
        end
      end
    end
    check("sum_idle", Sum, 4'(faces_m[2:0]) + 4'(faces_m[5:3]));
    check("sb_drained", sb_q.size(), 0);
    Roll = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_u;
    nReset = 1'b0; Roll = 1'b0; Hold = 2'b00;
    lfsr_m = 16'hACE1; faces_m = 6'b001_001; hold_m = 2'b00;
    roll2_lo = -2; roll2_hi = -2;

    // Face-step table: every (f, r, hold) combination
    for (int f = 0; f < 8; f++)
      for (int r = 0; r < 4; r++)
        for (int h = 0; h < 2; h++) begin
          uf = 3'(f); ur = 2'(r); uh = h[0];
          if (h != 0) exp_u = 3'(f);
          else        exp_u = model_next(3'(f), 2'(r));
          #1 check($sformatf("step_f%0d_r%0d_h%0d", f, r, h), unext, exp_u);
        end

    cyc(); cyc();
    check("rst_faces", DiceValue, 6'b001_001);
    check("rst_sum", Sum, 4'd2);
    check("rst_valid", Valid, 1'b0);
    check("rst_busy", Busy, 1'b0);
    nReset = 1'b1;
    cyc();

    // Single-cycle Roll pulse: steps at 2/6/14/30, Valid after 30
    roll_lo = 0; roll_hi = 0;
    steps_q = '{2, 6, 14, 30};
    run_roll(30, 2'b00);

    // Roll held 40 cycles: 20 tumble steps then three settle steps
    roll_lo = 0; roll_hi = 39;
    steps_q.delete();
    for (int s = 2; s <= 40; s += 2) steps_q.push_back(s);
    steps_q.push_back(44); steps_q.push_back(52); steps_q.push_back(68);
    run_roll(68, 2'b00);

    // Hold masks latched at roll start, later Hold changes ignored
    roll_lo = 0; roll_hi = 0;
    steps_q = '{2, 6, 14, 30};
    run_roll(30, 2'b10);
    steps_q = '{2, 6, 14, 30};
    run_roll(30, 2'b01);
    steps_q = '{2, 6, 14, 30};
    run_roll(30, 2'b11);

    // Re-roll during SETTLE k=2, then a full settle and one Valid
    roll_lo = 0; roll_hi = 0; roll2_lo = 10; roll2_hi = 13;
    steps_q = '{2, 6, 12, 14, 18, 26, 42};
    run_roll(42, 2'b00);
    roll2_lo = -2; roll2_hi = -2;

    // Asynchronous reset while settling
    Roll = 1'b1; Hold = 2'b00;
    cyc();
    Roll = 1'b0;
    cyc(); cyc(); cyc();
    check("pre_rst_busy", Busy, 1'b1);
    nReset = 1'b0;
    #1;
    check("midrst_faces", DiceValue, 6'b001_001);
    check("midrst_sum", Sum, 4'd2);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_valid", Valid, 1'b0);
    cyc();
    check("midrst_faces2", DiceValue, 6'b001_001);
    check("midrst_sum2", Sum, 4'd2);
    check("midrst_busy2", Busy, 1'b0);
    check("midrst_valid2", Valid, 1'b0);
    faces_m = 6'b001_001;
    lfsr_m  = 16'hACE1;
    nReset  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      check("post_rst_valid", Valid, 1'b0);
    end
    check("post_rst_faces", DiceValue, 6'b001_001);

    // A roll after reset restarts from the seed
    roll_lo = 0; roll_hi = 0;
    steps_q = '{2, 6, 14, 30};
    run_roll(30, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
